// File: rtl/myfilter_pkg.sv
// Shared definitions for the filter unit and its serial output stage.
// Contents:
//   DATABITS    - width of one filter result word
//   SER_GAP_W   - width of the inter-frame gap counter (covers GAP_CYCLES 0..15)
//   ser_state_t - serializer FSM states
package myfilter_pkg;

  localparam int DATABITS  = 16;
  localparam int SER_GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/ext_serializer_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy and no fall-through.
// A word written at edge t becomes visible at rd_data / !empty from t+1.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointers and level cleared)
//   wr_en     - push wr_data (ignored while full)
//   wr_data   - WIDTH-bit word to store
//   rd_en     - pop head (ignored while empty)
//   rd_data   - current head word (valid while !empty)
//   full      - level == DEPTH
//   empty     - level == 0
//   level     - occupancy, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_level == (AW+1)'(DEPTH));
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_push  = wr_en & ~full;
  assign w_pop   = rd_en & ~empty;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ext_serializer.sv
// ext_serializer: buffers parallel filter results in a small FIFO and emits
// each word MSB-first as a serial bitstream framed by sde_out.
// Optional feature: define EXT_SERIALIZER_PARITY_EN to append one even-parity
// bit (^word) after the data bits, still framed by sde_out.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (aborts any frame)
//   ext_in        - result word; accepted when extvalid_in & extready_out
//   extvalid_in   - ext_in valid
//   extready_out  - FIFO not full (from registered level only)
//   sd_out        - serial data, 0 whenever sde_out is 0
//   sde_out       - high exactly while sd_out carries a frame bit
//   level_out     - FIFO occupancy
//   busy_out      - FIFO non-empty or frame/gap in progress
module ext_serializer
  import myfilter_pkg::*;
#(
  parameter int DATABITS   = myfilter_pkg::DATABITS,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATABITS-1:0]           ext_in,
  input  logic                          extvalid_in,
  output logic                          extready_out,
  output logic                          sd_out,
  output logic                          sde_out,
  output logic [$clog2(FIFO_DEPTH):0]   level_out,
  output logic                          busy_out
);

`ifdef EXT_SERIALIZER_PARITY_EN
  localparam int FRAME_BITS = DATABITS + 1;
`else
  localparam int FRAME_BITS = DATABITS;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]     BIT_INIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [SER_GAP_W-1:0] GAP_INIT =
    (GAP_CYCLES > 0) ? SER_GAP_W'(GAP_CYCLES - 1) : '0;

  ser_state_t                 r_state, w_state_nxt;
  logic [FRAME_BITS-1:0]      r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic [SER_GAP_W-1:0]       r_gap_cnt, w_gap_cnt_nxt;
  logic                       r_sd, r_sde;
  logic                       w_pop;
  logic                       w_full, w_empty;
  logic [DATABITS-1:0]        w_head;
  logic [FRAME_BITS-1:0]      w_frame;
  logic [$clog2(FIFO_DEPTH):0] w_level;

  sync_fifo #(
    .WIDTH (DATABITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (extvalid_in & ~w_full),
    .wr_data (ext_in),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

`ifdef EXT_SERIALIZER_PARITY_EN
  assign w_frame = {w_head, ^w_head};
`else
  assign w_frame = w_head;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shreg_nxt   = w_frame;
          w_bit_cnt_nxt = BIT_INIT;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], 1'b0};
        if (r_bit_cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            w_gap_cnt_nxt = GAP_INIT;
            w_state_nxt   = GAP;
          end else if (!w_empty) begin
            // Reload on the last bit so the next frame follows with no bubble.
            w_pop         = 1'b1;
            w_shreg_nxt   = w_frame;
            w_bit_cnt_nxt = BIT_INIT;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = IDLE;
        else                 w_gap_cnt_nxt = r_gap_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_sd      <= 1'b0;
      r_sde     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      // Output bit is the MSB present while in SHIFT, registered one edge later.
      r_sde     <= (r_state == SHIFT);
      r_sd      <= (r_state == SHIFT) & r_shreg[FRAME_BITS-1];
    end
  end

  assign sd_out       = r_sd;
  assign sde_out      = r_sde;
  assign level_out    = w_level;
  assign extready_out = ~w_full;
  assign busy_out     = (w_level != '0) | (r_state != IDLE);

endmodule

// File: tb/tb_ext_serializer.sv
// Directed bench for ext_serializer (DATABITS=16, FIFO_DEPTH=4).
// u_a uses GAP_CYCLES=1, u_b uses GAP_CYCLES=0.
module tb_ext_serializer;

`ifdef EXT_SERIALIZER_PARITY_EN
  localparam int FB = 17;
`else
  localparam int FB = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ext_a = '0, ext_b = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        ready_a, ready_b, sd_a, sd_b, sde_a, sde_b, busy_a, busy_b;
  logic [2:0]  level_a, level_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ext_serializer #(.DATABITS(16), .FIFO_DEPTH(4), .GAP_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .ext_in(ext_a), .extvalid_in(valid_a),
    .extready_out(ready_a), .sd_out(sd_a), .sde_out(sde_a),
    .level_out(level_a), .busy_out(busy_a)
  );

  ext_serializer #(.DATABITS(16), .FIFO_DEPTH(4), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .ext_in(ext_b), .extvalid_in(valid_b),
    .extready_out(ready_b), .sd_out(sd_b), .sde_out(sde_b),
    .level_out(level_b), .busy_out(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected frame from word and its hand-computed even parity.
  function automatic logic [FB-1:0] exp_frame(input logic [15:0] w, input logic p);
    logic [16:0] full;
    full = {w, p};
    return FB'(full >> (17 - FB));
  endfunction

  // Frame capture and per-cycle invariants.
  logic [FB-1:0] acc_a, acc_b;
  int            cnt_a = 0, cnt_b = 0, run_b = 0, max_run_b = 0;
  logic [FB-1:0] got_a [$];
  logic [FB-1:0] got_b [$];

  always @(negedge clk) begin
    if (rst) begin
      cnt_a = 0;
      cnt_b = 0;
      run_b = 0;
    end else begin
      chk("sd_a_idle_zero", sd_a & ~sde_a, 0);
      chk("sd_b_idle_zero", sd_b & ~sde_b, 0);
      chk("ready_a_vs_level", ready_a, level_a < 3'd4);
      if (sde_a) begin
        acc_a = {acc_a[FB-2:0], sd_a};
        cnt_a++;
        if (cnt_a == FB) begin got_a.push_back(acc_a); cnt_a = 0; end
      end else cnt_a = 0;
      if (sde_b) begin
        acc_b = {acc_b[FB-2:0], sd_b};
        cnt_b++;
        run_b++;
        if (run_b > max_run_b) max_run_b = run_b;
        if (cnt_b == FB) begin got_b.push_back(acc_b); cnt_b = 0; end
      end else begin
        cnt_b = 0;
        run_b = 0;
      end
    end
  end

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while ((busy_a || sde_a) && n < budget) begin @(negedge clk); n++; end
    if (busy_a || sde_a) chk("wait_idle_a_timeout", 1, 0);
  endtask

  task automatic wait_frames_a(input int want, input int budget);
    int n = 0;
    while (got_a.size() < want && n < budget) begin @(negedge clk); n++; end
    if (got_a.size() < want) chk("frames_a_timeout", got_a.size(), want);
  endtask

  typedef struct {
    logic [15:0] word;
    logic        par;
  } vec_t;

  vec_t vecs [6];
  logic [15:0] burst [6];
  logic [15:0] bwords [3];

  initial begin
    logic [FB-1:0] fr;
    int guard;

    vecs[0] = '{16'hA5C3, 1'b0};
    vecs[1] = '{16'h0001, 1'b1};
    vecs[2] = '{16'h8000, 1'b1};
    vecs[3] = '{16'h1234, 1'b1};
    vecs[4] = '{16'h0007, 1'b1};
    vecs[5] = '{16'h0003, 1'b0};
    burst   = '{16'h0F0F, 16'hF00D, 16'h1357, 16'hCAFE, 16'hBEEF, 16'h2468};
    bwords  = '{16'h8001, 16'h7FFE, 16'hC3A5};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sde", sde_a, 0);
    chk("rst_sd", sd_a, 0);
    chk("rst_level", level_a, 0);
    chk("rst_busy", busy_a, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready_a, 1);
    chk("post_rst_level", level_a, 0);

    // Single words: exact latency, bit order, gap.
    for (int v = 0; v < 6; v++) begin
      wait_idle_a(100);
      fr = exp_frame(vecs[v].word, vecs[v].par);
      ext_a = vecs[v].word;
      valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0;
      chk("single_level_t", level_a, 1);
      chk("single_sde_t", sde_a, 0);
      @(negedge clk);
      chk("single_sde_t1", sde_a, 0);
      for (int i = 0; i < FB; i++) begin
        @(negedge clk);
        chk($sformatf("single%0d_sde_bit%0d", v, i), sde_a, 1);
        chk($sformatf("single%0d_sd_bit%0d", v, i), sd_a, fr[FB-1-i]);
      end
      @(negedge clk);
      chk("single_gap_sde", sde_a, 0);
    end

    // Burst with valid held: backpressure at level 4, simultaneous push/pop, order.
    wait_idle_a(100);
    got_a.delete();
    for (int k = 0; k < 6; k++) begin
      ext_a = burst[k];
      valid_a = 1'b1;
      guard = 0;
      while (!ready_a && guard < 200) begin @(negedge clk); guard++; end
      if (k == 5) chk("burst_free_level", level_a, 3);
      @(posedge clk);
      @(negedge clk);
      if (k == 1) chk("push_pop_level", level_a, 1);
      if (k == 4 || k == 5) begin
        chk("burst_full_level", level_a, 4);
        chk("burst_full_ready", ready_a, 0);
      end
    end
    valid_a = 1'b0;
    wait_frames_a(6, 400);
    for (int k = 0; k < 6; k++)
      if (k < got_a.size()) chk($sformatf("burst_order%0d", k), got_a[k], exp_frame(burst[k], ^burst[k]));

    // Back-to-back frames with no gap.
    for (int k = 0; k < 3; k++) begin
      ext_b = bwords[k];
      valid_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    valid_b = 1'b0;
    guard = 0;
    while ((busy_b || sde_b) && guard < 200) begin @(negedge clk); guard++; end
    chk("b2b_frames", got_b.size(), 3);
    chk("b2b_run", max_run_b, 3 * FB);
    for (int k = 0; k < 3; k++)
      if (k < got_b.size()) chk($sformatf("b2b_order%0d", k), got_b[k], exp_frame(bwords[k], ^bwords[k]));

    // Reset mid-frame after 8 bits of 16'hFFFF.
    wait_idle_a(100);
    got_a.delete();
    ext_a = 16'hFFFF;
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    guard = 0;
    while (cnt_a < 8 && guard < 50) begin @(negedge clk); guard++; end
    chk("midframe_reached", cnt_a >= 8, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_sde", sde_a, 0);
    chk("midrst_sd", sd_a, 0);
    chk("midrst_level", level_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_ready", ready_a, 1);
    rst = 1'b0;
    @(negedge clk);
    ext_a = 16'h1234;
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    wait_frames_a(1, 100);
    wait_idle_a(100);
    chk("postrst_frames", got_a.size(), 1);
    if (got_a.size() > 0) chk("postrst_word", got_a[0], exp_frame(16'h1234, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
